mvb_manchester_rx: RTL and testbench
====================================

Name: mvb_manchester_rx

Overview:
- Receive front end of the MVB link. Consumes the Manchester line driven by the encode path, after the external transceiver.
- Oversamples the line on clk_24M, recovers half-bit symbols and detects master/slave start delimiters.
- Decodes the Manchester payload MSB-first into 16-bit words and detects the end of frame.
- Raises decode_frame_over, which the encode controller uses to time its reply frames.

Parameters:
- HALF_BIT, 8: clk_24M cycles per half-bit (1.5 Mbit/s line).
- MASTER_DELIM, 16'hB1C5: master start delimiter as 8 bit-times of half-bit pairs (1 NH NL 0 NH NL 0 0), MSB first.
- SLAVE_DELIM, 16'hA8E3: slave start delimiter (1 1 1 NL NH 1 NL NH), MSB first.
- MAX_WORDS, 16: maximum data words per frame.

Ports:
- clk_24M  in  1  sole clock.
- rst  in  1  asynchronous reset, active-low.
- rx_en  in  1  receiver enable.
- line_in  in  1  raw asynchronous line from the transceiver.
- word_data  out  16  decoded word; valid only while word_valid is high.
- word_valid  out  1  one-cycle strobe per decoded word.
- frame_start  out  1  one-cycle strobe on delimiter match.
- frame_type  out  1  0 = master, 1 = slave; latched at frame_start.
- word_count  out  7  number of words in the current or last frame.
- decode_frame_over  out  1  one-cycle strobe on clean end of frame.
- frame_err  out  1  one-cycle strobe on a bad frame.
- err_code  out  2  1 = violation mid-word, 2 = overflow, 3 = empty frame; held until next frame_start.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, FSM in IDLE, shift registers cleared, half-bit counter 0.
- Input conditioning: line_in passes through a 2-FF synchronizer. An edge is any change between consecutive synchronized values.
- Half-bit counter: reloads to 0 on every edge; otherwise counts modulo HALF_BIT. A sample is taken when the counter equals HALF_BIT/2, giving 1 sample per half-bit.
- Tolerance: ±1 cycle edge jitter must not change the decoded result.
- Symbol pairs: "10" = 1, "01" = 0, "11" = NH, "00" = NL.
- IDLE state:
  - Each sample shifts into a 16-bit history register.
  - When the history equals MASTER_DELIM or SLAVE_DELIM and rx_en = 1: pulse frame_start the next cycle, latch frame_type, clear word_count and err_code, clear the pair/bit counters, enter DATA.
- DATA state:
  - Samples are consumed in pairs.
  - A valid pair shifts its bit into the word register, MSB first.
  - After the 16th bit, word_valid pulses for one cycle, 1 cycle after the final sample, and word_count increments.
- Invalid pair (NH or NL) in DATA:
  - bit index 0 and word_count ≥ 1: pulse decode_frame_over, go to IDLE.
  - bit index 0 and word_count = 0: frame_err with err_code 3, go to IDLE.
  - bit index ≠ 0: frame_err with err_code 1, go to IDLE; the partial word is discarded.
- Overflow: the word that would make word_count exceed MAX_WORDS is not emitted. Instead frame_err with err_code 2, go to IDLE. word_count saturates at MAX_WORDS.
- Line idle: a stuck line produces NH/NL pairs through the free-running counter, so the frame terminates through the invalid-pair rules above. No separate timeout exists.
- On return to IDLE the history register is cleared, so the frame tail cannot false-match a delimiter.
- Delimiter patterns appearing in DATA are ignored.
- rx_en low: in IDLE, no delimiter is accepted. Mid-frame, the FSM silently returns to IDLE with no strobes; word_count keeps its value.
- Pulse exclusivity: decode_frame_over, frame_err and word_valid are never asserted in the same cycle.

Decomposition:
- Package mvb_pkg:
  - delimiter default constants;
  - half-bit symbol encodings (SYM_ONE, SYM_ZERO, SYM_NH, SYM_NL);
  - err_code enum (ERR_NONE, ERR_VIOL, ERR_OVF, ERR_EMPTY);
  - FSM state typedef (IDLE, DATA).
- One sub-module, mvb_rx_sampler: synchronizer, edge detect and half-bit counter. Outputs sample_stb and sample_bit.
- Delimiter matching, FSM and deserialization stay in the top module.

Test Plan:
- Master delimiter, word 16'h1234, then NH pair -> frame_start, frame_type = 0, word_valid with word_data = 16'h1234, word_count = 1, decode_frame_over one pulse, frame_err never asserted.
- Slave delimiter, words 16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, then NL -> four word_valid strobes in order, frame_type = 1, word_count = 4, decode_frame_over.
- Slave delimiter, one word, then NH after 7 bits of the second word -> exactly one word_valid, frame_err with err_code = 1, no decode_frame_over.
- Slave delimiter followed by 17 words (MAX_WORDS = 16) -> 16 word_valid strobes, then frame_err with err_code = 2, word_count = 16.
- Master frame 16'hC3C3 with every edge shifted ±1 cycle at random -> identical decode to the clean case.
- Assert rst low mid-word of a slave frame, then resend the master frame 16'h0001 -> all outputs 0 during reset, then a clean decode with word_count = 1.

Source files
------------

// File: rtl/mvb_pkg.sv
// Shared constants and types for the MVB Manchester receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mvb_pkg;

  localparam int HALF_BIT_DEF = 8;
  localparam int MAX_WORDS_DEF = 16;

  // Start delimiters, one sample per half-bit, first sample in the MSB.
  localparam logic [15:0] MASTER_DELIM_DEF = 16'hB1C5;
  localparam logic [15:0] SLAVE_DELIM_DEF  = 16'hA8E3;

  // Half-bit pair encodings as {first half, second half}.
  localparam logic [1:0] SYM_ONE  = 2'b10;
  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_NH   = 2'b11;
  localparam logic [1:0] SYM_NL   = 2'b00;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_VIOL  = 2'd1,
    ERR_OVF   = 2'd2,
    ERR_EMPTY = 2'd3
  } err_code_t;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  // A pair carries a data bit only if its two halves differ.
  function automatic logic is_data_sym(input logic [1:0] pair);
    return (pair == SYM_ONE) || (pair == SYM_ZERO);
  endfunction

endpackage

// File: rtl/mvb_rx_sampler.sv
// Synchronizes the raw line and emits one mid-half-bit sample per half-bit.
// Latency: 2 sync stages; sample taken HALF_BIT/2+1 cycles after an edge.
// Backpressure: none; sample_stb is a free-running strobe.
module mvb_rx_sampler import mvb_pkg::*; #(
  parameter int HALF_BIT = HALF_BIT_DEF
) (
  input  logic clk_24M,
  input  logic rst,
  input  logic line_in,
  output logic sample_stb,
  output logic sample_bit
);

  localparam int CW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          line_edge;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign line_edge = sync2 ^ prev;

  // Half-bit phase counter: realigns on every edge, free-runs between edges
  // so flat stretches of line still produce one sample per half-bit.
  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (line_edge) begin
      cnt <= '0;
    end else if (cnt == CW'(HALF_BIT - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sample_stb = (cnt == CW'(HALF_BIT / 2));
  assign sample_bit = sync2;

endmodule

// File: rtl/mvb_manchester_rx.sv
// MVB receive front end: delimiter detection and MSB-first Manchester word decode.
// Latency: strobes one cycle after the deciding sample; samples trail the line by ~7 cycles.
// Backpressure: none; word_valid is a one-cycle strobe and must be taken when seen.
module mvb_manchester_rx import mvb_pkg::*; #(
  parameter int          HALF_BIT     = HALF_BIT_DEF,
  parameter logic [15:0] MASTER_DELIM = MASTER_DELIM_DEF,
  parameter logic [15:0] SLAVE_DELIM  = SLAVE_DELIM_DEF,
  parameter int          MAX_WORDS    = MAX_WORDS_DEF
) (
  input  logic        clk_24M,
  input  logic        rst,
  input  logic        rx_en,
  input  logic        line_in,
  output logic [15:0] word_data,
  output logic        word_valid,
  output logic        frame_start,
  output logic        frame_type,
  output logic [6:0]  word_count,
  output logic        decode_frame_over,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  logic        sample_stb;
  logic        sample_bit;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] history;
  logic        half_sel;
  logic        first_half;
  logic [3:0]  bit_idx;
  logic [15:0] shreg;

  logic [1:0]  pair;
  logic        pair_done;
  logic [15:0] word_nxt;

  logic        do_start;
  logic        do_emit;
  logic        do_over;
  logic        do_err;
  err_code_t   err_val;

  mvb_rx_sampler #(.HALF_BIT(HALF_BIT)) u_sampler (
    .clk_24M    (clk_24M),
    .rst        (rst),
    .line_in    (line_in),
    .sample_stb (sample_stb),
    .sample_bit (sample_bit)
  );

  assign pair      = {first_half, sample_bit};
  assign pair_done = sample_stb && half_sel;
  assign word_nxt  = {shreg[14:0], (pair == SYM_ONE)};

  // FSM state register.
  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and one-cycle decisions for the output strobes.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_emit   = 1'b0;
    do_over   = 1'b0;
    do_err    = 1'b0;
    err_val   = ERR_NONE;
    case (state)
      IDLE: begin
        if (rx_en && (history == MASTER_DELIM || history == SLAVE_DELIM)) begin
          do_start  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (!rx_en) begin
          state_nxt = IDLE;
        end else if (pair_done) begin
          if (is_data_sym(pair)) begin
            if (bit_idx == 4'd15) begin
              if (word_count == 7'(MAX_WORDS)) begin
                do_err    = 1'b1;
                err_val   = ERR_OVF;
                state_nxt = IDLE;
              end else begin
                do_emit = 1'b1;
              end
            end
          end else begin
            // A non-data pair on a word boundary is the frame end marker.
            if (bit_idx != 4'd0) begin
              do_err  = 1'b1;
              err_val = ERR_VIOL;
            end else if (word_count != 7'd0) begin
              do_over = 1'b1;
            end else begin
              do_err  = 1'b1;
              err_val = ERR_EMPTY;
            end
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered frame outputs and status held between frames.
  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      frame_start       <= 1'b0;
      word_valid        <= 1'b0;
      decode_frame_over <= 1'b0;
      frame_err         <= 1'b0;
      frame_type        <= 1'b0;
      word_data         <= '0;
      word_count        <= '0;
      err_code          <= ERR_NONE;
    end else begin
      frame_start       <= do_start;
      word_valid        <= do_emit;
      decode_frame_over <= do_over;
      frame_err         <= do_err;
      if (do_start) begin
        frame_type <= (history == SLAVE_DELIM);
        word_count <= '0;
        err_code   <= ERR_NONE;
      end
      if (do_err) begin
        err_code <= err_val;
      end
      if (do_emit) begin
        word_data  <= word_nxt;
        word_count <= word_count + 7'd1;
      end
    end
  end

  // Delimiter history shifts only while idle; held clear during a frame so the
  // tail of a frame can never complete a delimiter after returning to IDLE.
  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      history <= '0;
    end else if (state == DATA) begin
      history <= '0;
    end else if (sample_stb) begin
      history <= {history[14:0], sample_bit};
    end
  end

  // Pair assembly and word deserializer, restarted at every frame start.
  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      half_sel   <= 1'b0;
      first_half <= 1'b0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else if (do_start) begin
      half_sel   <= 1'b0;
      first_half <= 1'b0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else if (state == DATA && rx_en && sample_stb) begin
      if (!half_sel) begin
        first_half <= sample_bit;
        half_sel   <= 1'b1;
      end else begin
        half_sel <= 1'b0;
        if (is_data_sym(pair)) begin
          shreg   <= word_nxt;
          bit_idx <= bit_idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mvb_manchester_rx.sv
// Self-checking bench for mvb_manchester_rx: scoreboard of expected strobes
// popped by an independent monitor; line stimulus built from half-bit levels.
// Frames are generated at the half-bit level with optional +-1 cycle edge jitter.
module tb_mvb_manchester_rx;
  import mvb_pkg::*;

  logic        clk_24M = 1'b0;
  logic        rst = 1'b0;
  logic        rx_en = 1'b0;
  logic        line_in = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        frame_start;
  logic        frame_type;
  logic [6:0]  word_count;
  logic        decode_frame_over;
  logic        frame_err;
  logic [1:0]  err_code;

  mvb_manchester_rx dut (
    .clk_24M           (clk_24M),
    .rst               (rst),
    .rx_en             (rx_en),
    .line_in           (line_in),
    .word_data         (word_data),
    .word_valid        (word_valid),
    .frame_start       (frame_start),
    .frame_type        (frame_type),
    .word_count        (word_count),
    .decode_frame_over (decode_frame_over),
    .frame_err         (frame_err),
    .err_code          (err_code)
  );

  always #5 clk_24M = ~clk_24M;

  // Expected strobe events: kind 0 = frame_start(type), 1 = word(data),
  // 2 = frame over, 3 = frame error(code).
  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t  exp_q[$];
  logic halves[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   last_cnt = 0;
  int   last_err = 0;
  int   mon_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic pop_check(input int kind, input logic [15:0] val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected strobe (value %0h), nothing expected", name, val);
    end else begin
      e = exp_q.pop_front();
      check({name, " kind"}, kind, e.kind);
      check({name, " value"}, {16'h0, val}, {16'h0, e.val});
    end
  endtask

  // Monitor: compares every strobe the DUT raises against the scoreboard.
  always @(negedge clk_24M) begin
    if (rst) begin
      mon_n = int'(word_valid) + int'(decode_frame_over) + int'(frame_err);
      if (mon_n > 1) check("strobe exclusivity", mon_n, 1);
      if (frame_start)       pop_check(0, {15'h0, frame_type}, "frame_start");
      if (word_valid)        pop_check(1, word_data, "word_valid");
      if (decode_frame_over) pop_check(2, 16'h0, "frame_over");
      if (frame_err)         pop_check(3, {14'h0, err_code}, "frame_err");
    end
  end

  task automatic add_half(input logic b);
    halves.push_back(b);
  endtask

  task automatic add_bit(input logic b);
    add_half(b);
    add_half(~b);
  endtask

  task automatic add_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) add_bit(w[i]);
  endtask

  task automatic add_delim(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) add_half(d[i]);
  endtask

  // Drive the queued half-bit levels; with jitter each boundary moves by -1/0/+1 cycles.
  task automatic drive(input bit jitter);
    int jit[$];
    int n;
    n = halves.size();
    for (int i = 0; i <= n; i++)
      jit.push_back((jitter && i > 0 && i < n) ? int'($urandom_range(2)) - 1 : 0);
    for (int i = 0; i < n; i++) begin
      line_in = halves[i];
      repeat (HALF_BIT_DEF + jit[i+1] - jit[i]) @(negedge clk_24M);
    end
    halves.delete();
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk_24M);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk_24M);
      t++;
    end
    check({name, " scoreboard drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Reference model: a frame is delimiter + words + terminator.
  // term 0 = NH pair, 1 = NL pair, 2 = NH after vbits bits of vword.
  task automatic run_frame(input string name, input bit slave, input logic [15:0] w[$],
                           input int term, input int vbits, input logic [15:0] vword,
                           input bit jitter);
    int n;
    n = w.size();
    add_delim(slave ? SLAVE_DELIM_DEF : MASTER_DELIM_DEF);
    foreach (w[i]) add_bits(w[i], 16);
    if (term == 2) begin
      add_bits(vword, vbits);
      add_half(1'b1);
      add_half(1'b1);
    end else begin
      add_half(term == 0);
      add_half(term == 0);
    end

    exp_q.push_back('{0, {15'h0, slave}});
    if (n > MAX_WORDS_DEF) begin
      for (int i = 0; i < MAX_WORDS_DEF; i++) exp_q.push_back('{1, w[i]});
      exp_q.push_back('{3, 16'(ERR_OVF)});
      last_cnt = MAX_WORDS_DEF;
      last_err = ERR_OVF;
    end else begin
      foreach (w[i]) exp_q.push_back('{1, w[i]});
      last_cnt = n;
      if (term == 2) begin
        exp_q.push_back('{3, 16'(ERR_VIOL)});
        last_err = ERR_VIOL;
      end else if (n == 0) begin
        exp_q.push_back('{3, 16'(ERR_EMPTY)});
        last_err = ERR_EMPTY;
      end else begin
        exp_q.push_back('{2, 16'h0});
        last_err = ERR_NONE;
      end
    end

    drive(jitter);
    idle(40);
    drain(name);
    check({name, " word_count"}, word_count, last_cnt);
    check({name, " err_code"}, err_code, last_err);
    check({name, " frame_type"}, frame_type, slave);
    idle(40);
  endtask

  initial begin
    logic [15:0] wq[$];
    int          nw;
    int          tm;

    rst = 1'b0;
    rx_en = 1'b1;
    line_in = 1'b0;
    idle(5);
    check("reset word_data", word_data, 0);
    check("reset word_count", word_count, 0);
    check("reset err_code", err_code, 0);
    check("reset strobes", {word_valid, frame_start, decode_frame_over, frame_err, frame_type}, 0);
    rst = 1'b1;
    idle(40);

    wq = '{16'h1234};
    run_frame("master 1234", 1'b0, wq, 0, 0, 16'h0, 1'b0);

    wq = '{16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A};
    run_frame("slave four words", 1'b1, wq, 1, 0, 16'h0, 1'b0);

    wq = '{16'h0F0F};
    run_frame("slave violation", 1'b1, wq, 2, 7, 16'h9C3A, 1'b0);

    wq.delete();
    for (int i = 0; i < 17; i++) wq.push_back(16'($urandom));
    run_frame("slave overflow", 1'b1, wq, 0, 0, 16'h0, 1'b0);

    wq.delete();
    run_frame("empty frame", 1'b0, wq, 0, 0, 16'h0, 1'b0);

    wq = '{16'hC3C3};
    run_frame("master C3C3 clean", 1'b0, wq, 0, 0, 16'h0, 1'b0);
    run_frame("master C3C3 jitter", 1'b0, wq, 0, 0, 16'h0, 1'b1);

    // Receiver disabled: the delimiter must be ignored and status kept.
    rx_en = 1'b0;
    add_delim(MASTER_DELIM_DEF);
    add_bits(16'h7777, 16);
    add_half(1'b1);
    add_half(1'b1);
    drive(1'b0);
    idle(40);
    drain("rx_en low");
    check("rx_en low word_count kept", word_count, last_cnt);
    rx_en = 1'b1;
    idle(40);

    // Reset in the middle of the first word of a slave frame.
    add_delim(SLAVE_DELIM_DEF);
    add_bits(16'hABCD, 5);
    exp_q.push_back('{0, 16'h1});
    drive(1'b0);
    rst = 1'b0;
    idle(3);
    check("mid-frame reset word_count", word_count, 0);
    check("mid-frame reset err_code", err_code, 0);
    check("mid-frame reset word_data", word_data, 0);
    check("mid-frame reset strobes", {word_valid, frame_start, decode_frame_over, frame_err, frame_type}, 0);
    check("mid-frame reset scoreboard", exp_q.size(), 0);
    exp_q.delete();
    line_in = 1'b0;
    rst = 1'b1;
    idle(40);
    wq = '{16'h0001};
    run_frame("master 0001 after reset", 1'b0, wq, 0, 0, 16'h0, 1'b0);

    // Randomized frames against the same model.
    for (int f = 0; f < 6; f++) begin
      wq.delete();
      nw = int'($urandom_range(4));
      for (int i = 0; i < nw; i++) wq.push_back(16'($urandom));
      tm = int'($urandom_range(2));
      run_frame("random frame", 1'($urandom), wq, tm, int'($urandom_range(15, 1)),
                16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
